// File: rtl/double_pkg.sv
// Shared binary64 field widths, class encoding and operand struct for the double_* library.
package double_pkg;

    localparam int unsigned DBL_W  = 64;
    localparam int unsigned EXP_W  = 11;
    localparam int unsigned MANT_W = 52;
    localparam int unsigned CLS_W  = 5;

    localparam logic [EXP_W-1:0] EXP_MAX = 11'h7FF;

    // One-hot bit positions of the operand class
    localparam int unsigned CLS_ZERO_BIT = 0;
    localparam int unsigned CLS_SUB_BIT  = 1;
    localparam int unsigned CLS_NORM_BIT = 2;
    localparam int unsigned CLS_INF_BIT  = 3;
    localparam int unsigned CLS_NAN_BIT  = 4;

    localparam logic [CLS_W-1:0] CLS_ZERO = CLS_W'(1) << CLS_ZERO_BIT;

    // Quiet bit of a NaN mantissa
    localparam int unsigned QUIET_BIT = MANT_W - 1;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } double_t;

endpackage

// File: rtl/double_classify.sv
// Combinational binary64 classifier: one-hot class and signalling-NaN flag.
// The sign bit does not affect the class.
module double_classify
    import double_pkg::*;
(
    input  double_t            a,
    output logic [CLS_W-1:0]   cls_c,
    output logic               is_snan_c
);

    logic exp_zero;
    logic exp_max;
    logic mant_zero;
    logic unused_sign;

    assign exp_zero    = (a.exp == '0);
    assign exp_max     = (a.exp == EXP_MAX);
    assign mant_zero   = (a.mant == '0);
    assign unused_sign = a.sign;

    // Decode the exponent/mantissa into exactly one class bit
    always_comb begin
        cls_c     = '0;
        is_snan_c = 1'b0;
        if (exp_zero) begin
            if (mant_zero) cls_c[CLS_ZERO_BIT] = 1'b1;
            else           cls_c[CLS_SUB_BIT]  = 1'b1;
        end else if (exp_max) begin
            if (mant_zero) begin
                cls_c[CLS_INF_BIT] = 1'b1;
            end else begin
                cls_c[CLS_NAN_BIT] = 1'b1;
                is_snan_c          = ~a.mant[QUIET_BIT];
            end
        end else begin
            cls_c[CLS_NORM_BIT] = 1'b1;
        end
    end

endmodule

// File: rtl/double_abs.sv
// Registered binary64 absolute value with one-hot result class.
// Optional macro DOUBLE_ABS_NAN_QUIET_EN: quiet signalling NaNs and flag invalid.
module double_abs
    import double_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [DBL_W-1:0]   a,
    output logic [DBL_W-1:0]   z,
    output logic [CLS_W-1:0]   cls,
    output logic               invalid
);

    double_t            a_s;
    logic [CLS_W-1:0]   cls_c;
    logic               is_snan_c;
    logic [DBL_W-1:0]   z_c;
    logic               invalid_c;

    assign a_s = double_t'(a);

    double_classify u_classify (
        .a         (a_s),
        .cls_c     (cls_c),
        .is_snan_c (is_snan_c)
    );

    // Clear the sign; optionally force the quiet bit on signalling NaNs
    always_comb begin
        z_c       = {1'b0, a[DBL_W-2:0]};
        invalid_c = 1'b0;
`ifdef DOUBLE_ABS_NAN_QUIET_EN
        if (is_snan_c) begin
            z_c[QUIET_BIT] = 1'b1;
            invalid_c      = 1'b1;
        end
`endif
    end

`ifndef DOUBLE_ABS_NAN_QUIET_EN
    logic unused_snan;
    assign unused_snan = is_snan_c;
`endif

    // Single output register stage; reset reports a positive zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z       <= '0;
            cls     <= CLS_ZERO;
            invalid <= 1'b0;
        end else begin
            z       <= z_c;
            cls     <= cls_c;
            invalid <= invalid_c;
        end
    end

endmodule

// File: tb/tb_double_abs.sv
// Directed and random checks for double_abs (honours DOUBLE_ABS_NAN_QUIET_EN).
module tb_double_abs;

    typedef struct {
        logic [63:0] a;
        logic [63:0] z;
        logic [4:0]  cls;
        logic        inv;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] a;
    logic [63:0] z;
    logic [4:0]  cls;
    logic        invalid;

    int n_cmp = 0;
    int n_err = 0;

    double_abs dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .z       (z),
        .cls     (cls),
        .invalid (invalid)
    );

    always #5 clk = ~clk;

`ifdef DOUBLE_ABS_NAN_QUIET_EN
    localparam bit QUIET = 1'b1;
`else
    localparam bit QUIET = 1'b0;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] m_cls(input logic [63:0] x);
        logic [10:0] e;
        logic [51:0] m;
        e = x[62:52];
        m = x[51:0];
        if (e == 11'd0)   return (m == 52'd0) ? 5'b00001 : 5'b00010;
        if (e == 11'h7FF) return (m == 52'd0) ? 5'b01000 : 5'b10000;
        return 5'b00100;
    endfunction

    function automatic logic m_snan(input logic [63:0] x);
        return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0) && !x[51];
    endfunction

    function automatic logic [63:0] m_z(input logic [63:0] x);
        logic [63:0] r;
        r = x & 64'h7FFF_FFFF_FFFF_FFFF;
        if (QUIET && m_snan(x)) r = r | 64'h0008_0000_0000_0000;
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[12];
        logic [63:0] prev_z;
        logic [63:0] r;

        vecs[0]  = '{64'hC000_0000_0000_0000, 64'h4000_0000_0000_0000, 5'b00100, 1'b0};
        vecs[1]  = '{64'h8000_0000_0000_0000, 64'h0000_0000_0000_0000, 5'b00001, 1'b0};
        vecs[2]  = '{64'h8000_0000_0000_000F, 64'h0000_0000_0000_000F, 5'b00010, 1'b0};
        vecs[3]  = '{64'hFFF0_0000_0000_0000, 64'h7FF0_0000_0000_0000, 5'b01000, 1'b0};
        vecs[4]  = '{64'hFFF8_0000_0000_0000, 64'h7FF8_0000_0000_0000, 5'b10000, 1'b0};
        vecs[5]  = '{64'hFFF0_0000_0000_0001,
                     QUIET ? 64'h7FF8_0000_0000_0001 : 64'h7FF0_0000_0000_0001, 5'b10000, QUIET};
        vecs[6]  = '{64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 5'b00100, 1'b0};
        vecs[7]  = '{64'hFFEF_FFFF_FFFF_FFFF, 64'h7FEF_FFFF_FFFF_FFFF, 5'b00100, 1'b0};
        vecs[8]  = '{64'h8010_0000_0000_0000, 64'h0010_0000_0000_0000, 5'b00100, 1'b0};
        vecs[9]  = '{64'h000F_FFFF_FFFF_FFFF, 64'h000F_FFFF_FFFF_FFFF, 5'b00010, 1'b0};
        vecs[10] = '{64'h7FF7_FFFF_FFFF_FFFF,
                     QUIET ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h7FF7_FFFF_FFFF_FFFF, 5'b10000, QUIET};
        vecs[11] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 5'b10000, 1'b0};

        rst = 1'b1;
        a   = 64'hC000_0000_0000_0000;
        #3;
        chk("reset_z", z, 64'h0);
        chk("reset_cls", 64'(cls), 64'h1);
        chk("reset_inv", 64'(invalid), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table: output holds until the edge, then shows the vector's result
        prev_z = 64'h0;
        for (int i = 0; i < 12; i++) begin
            a = vecs[i].a;
            #1;
            chk($sformatf("hold_z[%0d]", i), z, prev_z);
            @(posedge clk);
            #1;
            chk($sformatf("vec_z[%0d]", i), z, vecs[i].z);
            chk($sformatf("vec_cls[%0d]", i), 64'(cls), 64'(vecs[i].cls));
            chk($sformatf("vec_inv[%0d]", i), 64'(invalid), 64'(vecs[i].inv));
            prev_z = vecs[i].z;
            @(negedge clk);
        end

        // Back-to-back random stream biased toward zero/max exponents
        for (int i = 0; i < 1000; i++) begin
            r = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: r[62:52] = 11'd0;
                1: r[62:52] = 11'h7FF;
                default: ;
            endcase
            if ($urandom_range(0, 7) == 0) r[51:0] = 52'd0;
            a = r;
            #1;
            chk("rnd_hold", z, prev_z);
            @(posedge clk);
            #1;
            chk("rnd_z", z, m_z(r));
            chk("rnd_cls", 64'(cls), 64'(m_cls(r)));
            chk("rnd_onehot", 64'($onehot(cls)), 64'h1);
            chk("rnd_inv", 64'(invalid), 64'(QUIET && m_snan(r)));
            prev_z = m_z(r);
            @(negedge clk);
        end

        // Asynchronous reset mid-stream with a signalling NaN in the register
        a = 64'hFFF0_0000_0000_0001;
        @(posedge clk);
        #1;
        chk("pre_rst_z", z, QUIET ? 64'h7FF8_0000_0000_0001 : 64'h7FF0_0000_0000_0001);
        chk("pre_rst_inv", 64'(invalid), 64'(QUIET));
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_z", z, 64'h0);
        chk("async_rst_cls", 64'(cls), 64'h1);
        chk("async_rst_inv", 64'(invalid), 64'h0);
        a = 64'hBFF0_0000_0000_0000;
        @(posedge clk);
        #1;
        chk("rst_held_z", z, 64'h0);
        #2;
        rst = 1'b0;
        #1;
        chk("rel_hold_z", z, 64'h0);
        chk("rel_hold_cls", 64'(cls), 64'h1);
        @(posedge clk);
        #1;
        chk("rel_first_z", z, 64'h3FF0_0000_0000_0000);
        chk("rel_first_cls", 64'(cls), 64'h4);
        chk("rel_first_inv", 64'(invalid), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
